mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is required to work.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation in the current cycle.
REQ-005 SHALL have port op  input  2  MDUop_MULT / MDUop_MULTU / MDUop_DIV / MDUop_DIVU.
REQ-006 SHALL have ports a, b  input  WIDTH  operands (multiplicand/dividend, multiplier/divisor).
REQ-007 SHALL have ports hi_we, lo_we  input  1  MTHI/MTLO write strobes.
REQ-008 SHALL have port wdata  input  WIDTH  MTHI/MTLO data.
REQ-009 SHALL have port busy  output  1  operation in flight; pipeline stalls on MFHI/MFLO/new mult-div.
REQ-010 SHALL have port done  output  1  one-cycle pulse when HI/LO receive a result.
REQ-011 SHALL have ports hi, lo  output  WIDTH  architectural HI/LO registers.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIX.
REQ-013 SHALL accept start only in IDLE; start while busy=1 is ignored with no side effect.
REQ-014 SHALL latch op, a and b on acceptance and move IDLE->RUN; signed ops latch operand magnitudes plus sign flags.
REQ-015 SHALL stay in RUN exactly WIDTH cycles: multiply does one shift-add step per cycle; divide does one restoring shift-subtract step per cycle. A 5-bit step counter counts 0..31 and does not wrap.
REQ-016 SHALL move RUN->FIX after step 31, and FIX->IDLE after exactly one cycle.
REQ-017 SHALL apply sign correction in FIX: negate the product if the operand signs differ; negate the quotient if the signs differ; give the remainder the sign of the dividend.
REQ-018 SHALL place results as follows: multiply {hi,lo}=64-bit product; divide lo=quotient, hi=remainder.
REQ-019 SHALL treat divide by zero as defined behaviour: lo=32'hFFFF_FFFF and hi=a, for both signed and unsigned.
REQ-020 SHALL give DIV 0x8000_0000 / 0xFFFF_FFFF the result lo=0x8000_0000, hi=0.
REQ-021 SHALL hold busy high from the cycle after acceptance through the FIX cycle, i.e. 33 cycles.
REQ-022 SHALL update hi/lo and pulse done in the cycle after FIX. A start accepted at cycle N gives done=1 at cycle N+34.
REQ-023 SHALL keep hi/lo unchanged during RUN/FIX; intermediate values live in internal registers only.
REQ-024 SHALL, in IDLE, write wdata to hi on hi_we and to lo on lo_we; both strobes may be set in the same cycle.
REQ-025 SHALL ignore hi_we/lo_we while busy=1.
REQ-026 SHALL, when start and hi_we/lo_we occur in the same IDLE cycle, perform the MT write; the operation result later overwrites HI/LO.
REQ-027 SHALL accept a start asserted in the same cycle as done; back-to-back operations are allowed.

Reset
REQ-028 SHALL on rst force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0.
REQ-029 SHALL let rst abort any operation mid-flight, with no result written.
REQ-030 SHALL give rst priority over start and hi_we/lo_we.

Configuration
REQ-031 SHALL compile the divider in only when macro MDU_DIV_EN is defined.
REQ-032 SHALL, without MDU_DIV_EN, treat DIV/DIVU starts as ignored: busy stays 0, no done, hi/lo unchanged, and no divider logic is synthesised.

Structure
REQ-033 SHALL import the op encoding from package MDUops, which also holds the state enum and the width constant.
REQ-034 SHALL place the per-step datapath (shift-add / shift-subtract over a 2*WIDTH+1 accumulator) in sub-module mdu_iter_core; mdu_ctrl owns the FSM, counter, sign logic and HI/LO.

Verification
REQ-035 SHALL cover: MULT a=0xFFFF_FFFD, b=7 -> done at N+34, hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
REQ-036 SHALL cover: MULTU a=b=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001.
REQ-037 SHALL cover: DIV a=0xFFFF_FFF9 (-7), b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU a=5, b=0 -> lo=0xFFFF_FFFF, hi=5.
REQ-038 SHALL cover: second start plus hi_we during busy -> both ignored; a single done pulse; hi/lo equal the first op's result.
REQ-039 SHALL cover: rst at step 10 of a MULT -> next cycle busy=0, hi=lo=0, and no done follows.
REQ-040 SHALL cover: without MDU_DIV_EN, DIV start -> busy stays 0 for 40 cycles and hi/lo are unchanged.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// MDUops: op encoding, FSM state constants and default width shared by the mult/div unit.
// The divider is only built when MDU_DIV_EN is defined; this package is the same in both builds.
package MDUops;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] MDUop_MULT  = 2'd0;
  localparam logic [1:0] MDUop_MULTU = 2'd1;
  localparam logic [1:0] MDUop_DIV   = 2'd2;
  localparam logic [1:0] MDUop_DIVU  = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_ctrl_iter_core.sv
// mdu_iter_core: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle
// over a 2*WIDTH+1 accumulator. Divide step exists only when MDU_DIV_EN is defined.
module mdu_iter_core
  import MDUops::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic                 is_div_i,
  input  logic [WIDTH-1:0]     opa_i,
  input  logic [WIDTH-1:0]     opb_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [2*WIDTH:0]   acc_q;
  logic [WIDTH-1:0]   opd_q;
  logic [2*WIDTH:0]   acc_load;
  logic [WIDTH-1:0]   opd_load;
  logic [2*WIDTH:0]   step_next;

  // Multiply: low half holds the remaining multiplier bits, product grows in from the top.
  logic [WIDTH:0]     mul_hi;
  logic [2*WIDTH:0]   mul_next;
  assign mul_hi   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
  assign mul_next = {1'b0, mul_hi, acc_q[WIDTH-1:1]};

`ifdef MDU_DIV_EN
  logic               div_q;
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH:0]   div_next;

  // Remainder sits in the upper part, quotient bits shift in at bit 0.
  assign div_sh    = {acc_q[2*WIDTH-1:0], 1'b0};
  assign div_trial = div_sh[2*WIDTH:WIDTH] - {1'b0, opd_q};
  assign div_next  = div_trial[WIDTH] ? div_sh : {div_trial, div_sh[WIDTH-1:1], 1'b1};

  assign acc_load  = {{(WIDTH+1){1'b0}}, is_div_i ? opa_i : opb_i};
  assign opd_load  = is_div_i ? opb_i : opa_i;
  assign step_next = div_q ? div_next : mul_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= 1'b0;
    end else if (load_i) begin
      div_q <= is_div_i;
    end
  end
`else
  logic unused_is_div;
  assign unused_is_div = is_div_i;
  assign acc_load      = {{(WIDTH+1){1'b0}}, opb_i};
  assign opd_load      = opa_i;
  assign step_next     = mul_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      opd_q <= '0;
    end else if (load_i) begin
      acc_q <= acc_load;
      opd_q <= opd_load;
    end else if (step_i) begin
      acc_q <= step_next;
    end
  end

  logic unused_acc_top;
  assign unused_acc_top = acc_q[2*WIDTH];
  assign acc_o          = acc_q[2*WIDTH-1:0];

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle MULT/MULTU (and DIV/DIVU when MDU_DIV_EN is defined) with HI/LO registers.
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes allowed
// RUN   | WIDTH iteration steps in mdu_iter_core
// FIX   | sign correction; HI/LO and done update at the end of this cycle
module mdu_ctrl
  import MDUops::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [WIDTH-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  localparam logic [4:0] LAST_STEP = 5'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;
  logic               sa_q, sb_q;
  logic               op_ok, accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] core_acc;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MDU_DIV_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~op_is_div(op);
`endif

  assign accept = (state_q == ST_IDLE) && start && op_ok;
  assign a_neg  = op_is_signed(op) & a[WIDTH-1];
  assign b_neg  = op_is_signed(op) & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept),
    .step_i   (state_q == ST_RUN),
    .is_div_i (op_is_div(op)),
    .opa_i    (a_mag),
    .opb_i    (b_mag),
    .acc_o    (core_acc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (cnt_q == LAST_STEP) begin
          state_d = ST_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MDU_DIV_EN
  logic div_q, bzero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= 1'b0;
      bzero_q <= 1'b0;
    end else if (accept) begin
      div_q   <= op_is_div(op);
      bzero_q <= (b == '0);
    end
  end
`endif

  assign prod_s = (sa_q ^ sb_q) ? -core_acc : core_acc;

  always_comb begin
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
`ifdef MDU_DIV_EN
    // Divide by zero keeps the dividend as remainder; only the quotient needs forcing.
    if (div_q) begin
      res_lo = bzero_q ? '1 :
               ((sa_q ^ sb_q) ? -core_acc[WIDTH-1:0] : core_acc[WIDTH-1:0]);
      res_hi = sa_q ? -core_acc[2*WIDTH-1:WIDTH] : core_acc[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_q == ST_FIX);
      if (accept) begin
        sa_q <= a_neg;
        sb_q <= b_neg;
      end
      if (state_q == ST_FIX) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (state_q == ST_IDLE) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl; divide vectors run when MDU_DIV_EN is defined,
// otherwise the bench checks that DIV/DIVU starts are ignored.
module tb_mdu_ctrl;
  import MDUops::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start, then samples for 'budget' cycles; k=1 is the cycle after acceptance.
  task automatic drive_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int budget, output int done_at, output int n_done, output int n_busy);
    start = 1'b1; op = o; a = x; b = y;
    done_at = -1; n_done = 0; n_busy = 0;
    for (int k = 1; k <= budget; k++) begin
      tick();
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = k;
      end
    end
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [W-1:0] d);
    hi_we = h; lo_we = l; wdata = d;
    tick();
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = MDUop_MULT; a = 32'd3; b = 32'd3;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hFFFF_0000;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
    rst = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_mult();
    int da, nd, nb;
    drive_op(MDUop_MULT, 32'hFFFF_FFFD, 32'd7, 40, da, nd, nb);
    n_checks++; if (da !== 34) begin n_fail++; $display("FAIL mult_done_cycle: got %0d expected 34", da); end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL mult_done_count: got %0d expected 1", nd); end
    n_checks++; if (nb !== 33) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected 33", nb); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h expected ffffffeb", lo); end
    drive_op(MDUop_MULT, 32'h8000_0000, 32'h8000_0000, 40, da, nd, nb);
    n_checks++; if (hi !== 32'h4000_0000) begin n_fail++; $display("FAIL mult_min_hi: got %h expected 40000000", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL mult_min_lo: got %h expected 0", lo); end
    drive_op(MDUop_MULT, 32'd12, 32'hFFFF_FFFB, 40, da, nd, nb);
    n_checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFC4) begin n_fail++; $display("FAIL mult_neg_b: got %h expected ffffffffffffffc4", {hi, lo}); end
  endtask

  task automatic test_multu();
    int da, nd, nb;
    drive_op(MDUop_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 40, da, nd, nb);
    n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
    n_checks++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
    n_checks++; if (da !== 34) begin n_fail++; $display("FAIL multu_done_cycle: got %0d expected 34", da); end
    drive_op(MDUop_MULTU, 32'h1234_5678, 32'h0, 40, da, nd, nb);
    n_checks++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL multu_zero: got %h expected 0", {hi, lo}); end
  endtask

  task automatic test_mt_write();
    mt_write(1'b1, 1'b1, 32'hA5A5_5A5A);
    n_checks++; if (hi !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL mt_both_hi: got %h expected a5a55a5a", hi); end
    n_checks++; if (lo !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL mt_both_lo: got %h expected a5a55a5a", lo); end
    mt_write(1'b1, 1'b0, 32'h0000_1234);
    n_checks++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi_only_hi: got %h expected 00001234", hi); end
    n_checks++; if (lo !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL mthi_only_lo: got %h expected a5a55a5a", lo); end
  endtask

  task automatic test_start_with_mt();
    int da = -1;
    int nd = 0;
    start = 1'b1; op = MDUop_MULTU; a = 32'd3; b = 32'd5;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    n_checks++; if (hi !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL start_mt_hi: got %h expected deadbeef", hi); end
    n_checks++; if (lo !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL start_mt_lo: got %h expected deadbeef", lo); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_mt_busy: got %b expected 1", busy); end
    for (int k = 2; k <= 40; k++) begin
      tick();
      if (done) begin nd++; if (da < 0) da = k; end
    end
    n_checks++; if (da !== 34) begin n_fail++; $display("FAIL start_mt_done_cycle: got %0d expected 34", da); end
    n_checks++; if ({hi, lo} !== 64'd15) begin n_fail++; $display("FAIL start_mt_result: got %h expected f", {hi, lo}); end
  endtask

  task automatic test_busy_ignore();
    int da = -1;
    int nd = 0;
    mt_write(1'b1, 1'b1, 32'h77);
    start = 1'b1; op = MDUop_MULT; a = 32'd6; b = 32'd7;
    for (int k = 1; k <= 45; k++) begin
      tick();
      start = 1'b0; hi_we = 1'b0;
      if (done) begin nd++; if (da < 0) da = k; end
      if (k == 5) begin
        start = 1'b1; op = MDUop_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        hi_we = 1'b1; wdata = 32'h5555;
      end
      if (k == 6) begin
        n_checks++; if (hi !== 32'h77) begin n_fail++; $display("FAIL busy_mthi_ignored: got %h expected 77", hi); end
      end
    end
    n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL busy_single_done: got %0d expected 1", nd); end
    n_checks++; if (da !== 34) begin n_fail++; $display("FAIL busy_done_cycle: got %0d expected 34", da); end
    n_checks++; if ({hi, lo} !== 64'd42) begin n_fail++; $display("FAIL busy_result: got %h expected 2a", {hi, lo}); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_no_second_op: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    int nd = 0;
    start = 1'b1; op = MDUop_MULTU; a = 32'd2; b = 32'd3;
    for (int k = 1; k <= 80; k++) begin
      tick();
      start = 1'b0;
      if (done) begin
        nd++;
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
      if (k == 34 && done) begin
        n_checks++; if ({hi, lo} !== 64'd6) begin n_fail++; $display("FAIL b2b_first_result: got %h expected 6", {hi, lo}); end
        start = 1'b1; op = MDUop_MULTU; a = 32'd4; b = 32'd5;
      end
    end
    n_checks++; if (d1 !== 34) begin n_fail++; $display("FAIL b2b_first_done: got %0d expected 34", d1); end
    n_checks++; if (d2 !== 68) begin n_fail++; $display("FAIL b2b_second_done: got %0d expected 68", d2); end
    n_checks++; if (nd !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 2", nd); end
    n_checks++; if ({hi, lo} !== 64'd20) begin n_fail++; $display("FAIL b2b_second_result: got %h expected 14", {hi, lo}); end
  endtask

  task automatic test_reset_abort();
    int da, nd, nb;
    mt_write(1'b1, 1'b1, 32'hABCD);
    drive_op(MDUop_MULT, 32'd9, 32'd9, 11, da, nd, nb);
    rst = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL abort_hi: got %h expected 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL abort_lo: got %h expected 0", lo); end
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) nd++;
    end
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", nd); end
    n_checks++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL abort_no_result: got %h expected 0", {hi, lo}); end
  endtask

`ifdef MDU_DIV_EN
  typedef struct {
    logic [1:0]   o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] ehi;
    logic [W-1:0] elo;
  } div_vec_t;

  task automatic test_div();
    div_vec_t dv [6];
    int da, nd, nb;
    dv[0] = '{MDUop_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    dv[1] = '{MDUop_DIVU, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    dv[2] = '{MDUop_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    dv[3] = '{MDUop_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    dv[4] = '{MDUop_DIVU, 32'd100,       32'd7,         32'd2,         32'd14};
    dv[5] = '{MDUop_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    for (int i = 0; i < 6; i++) begin
      drive_op(dv[i].o, dv[i].x, dv[i].y, 40, da, nd, nb);
      n_checks++; if (da !== 34) begin n_fail++; $display("FAIL div%0d_done_cycle: got %0d expected 34", i, da); end
      n_checks++; if (hi !== dv[i].ehi) begin n_fail++; $display("FAIL div%0d_hi: got %h expected %h", i, hi, dv[i].ehi); end
      n_checks++; if (lo !== dv[i].elo) begin n_fail++; $display("FAIL div%0d_lo: got %h expected %h", i, lo, dv[i].elo); end
    end
  endtask
`else
  task automatic test_no_div();
    int da, nd, nb;
    mt_write(1'b1, 1'b0, 32'h1357_9BDF);
    mt_write(1'b0, 1'b1, 32'h2468_ACE0);
    drive_op(MDUop_DIV, 32'd100, 32'd7, 40, da, nd, nb);
    n_checks++; if (nb !== 0) begin n_fail++; $display("FAIL nodiv_busy: got %0d busy cycles expected 0", nb); end
    n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL nodiv_done: got %0d expected 0", nd); end
    n_checks++; if (hi !== 32'h1357_9BDF) begin n_fail++; $display("FAIL nodiv_hi: got %h expected 13579bdf", hi); end
    n_checks++; if (lo !== 32'h2468_ACE0) begin n_fail++; $display("FAIL nodiv_lo: got %h expected 2468ace0", lo); end
    drive_op(MDUop_DIVU, 32'd5, 32'd0, 40, da, nd, nb);
    n_checks++; if (nb !== 0 || nd !== 0) begin n_fail++; $display("FAIL nodiv_divu: got busy %0d done %0d expected 0 0", nb, nd); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; op = MDUop_MULT; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    test_reset();
    test_mult();
    test_multu();
    test_mt_write();
    test_start_with_mt();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
`ifdef MDU_DIV_EN
    test_div();
`else
    test_no_div();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
